// File: rtl/im2col_stream_pkg.sv
// Shared definitions for the im2col streaming stage: element width default, FSM states,
// output-grid derivation (padding when IM2COL_PAD_EN is defined) and flat index helper.
package im2col_stream_pkg;

   localparam int DATA_LEN_DEF = 16;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   function automatic int pad_of(input int k);
`ifdef IM2COL_PAD_EN
      return (k - 1) / 2;
`else
      return 0;
`endif
   endfunction

   function automatic int out_dim(input int n, input int k);
      return n - k + 1 + 2 * pad_of(k);
   endfunction

   // Counter width never collapses to zero bits, even for a 1x1 output grid.
   function automatic int cnt_w(input int n);
      return (n > 1) ? clog2(n) : 1;
   endfunction

   function automatic int flat_idx(input int c, input int y, input int x,
                                   input int h, input int w);
      return c * h * w + y * w + x;
   endfunction

endpackage

// File: rtl/im2col_patch_sel.sv
// Combinational gather of one C*K*K patch at output position (y,x) from a C*H*W map.
// With IM2COL_PAD_EN defined, taps outside the map read as zero.
module im2col_patch_sel
   import im2col_stream_pkg::*;
#(
   parameter int DATA_LEN = DATA_LEN_DEF,
   parameter int C        = 32,
   parameter int H        = 5,
   parameter int W        = 6,
   parameter int K        = 3,
   parameter int YW       = 2,
   parameter int XW       = 2
) (
   input  logic [C*H*W*DATA_LEN-1:0] i_buf,
   input  logic [YW-1:0]             i_y,
   input  logic [XW-1:0]             i_x,
   output logic [C*K*K*DATA_LEN-1:0] o_patch
);
   localparam int P = pad_of(K);

   // Patch element (c,r,s) takes map element (c, y+r-P, x+s-P).
   always_comb begin
      int row;
      int col;
      row     = 0;
      col     = 0;
      o_patch = '0;
      for (int c = 0; c < C; c++) begin
         for (int r = 0; r < K; r++) begin
            for (int s = 0; s < K; s++) begin
               row = int'(i_y) + r - P;
               col = int'(i_x) + s - P;
`ifdef IM2COL_PAD_EN
               if (row >= 0 && row < H && col >= 0 && col < W) begin
                  o_patch[(c*K*K + r*K + s)*DATA_LEN +: DATA_LEN] =
                     i_buf[flat_idx(c, row, col, H, W)*DATA_LEN +: DATA_LEN];
               end else begin
                  o_patch[(c*K*K + r*K + s)*DATA_LEN +: DATA_LEN] = '0;
               end
`else
               o_patch[(c*K*K + r*K + s)*DATA_LEN +: DATA_LEN] =
                  i_buf[flat_idx(c, row, col, H, W)*DATA_LEN +: DATA_LEN];
`endif
            end
         end
      end
   end

endmodule

// File: rtl/im2col_stream.sv
// Captures a C x H x W feature map and streams its im2col patches in raster order over
// valid/ready. Define IM2COL_PAD_EN for "same" zero padding (output grid becomes H x W).
module im2col_stream
   import im2col_stream_pkg::*;
#(
   parameter int  DATA_LEN = DATA_LEN_DEF,
   parameter int  C        = 32,
   parameter int  H        = 5,
   parameter int  W        = 6,
   parameter int  K        = 3,
   localparam int OH       = out_dim(H, K),
   localparam int OW       = out_dim(W, K),
   localparam int YW       = cnt_w(OH),
   localparam int XW       = cnt_w(OW)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [C*H*W*DATA_LEN-1:0] d,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [C*K*K*DATA_LEN-1:0] q,
   output logic [YW-1:0]             out_y,
   output logic [XW-1:0]             out_x,
   output logic                      out_last
);
   localparam logic [YW-1:0] LAST_Y = YW'(OH - 1);
   localparam logic [XW-1:0] LAST_X = XW'(OW - 1);

   state_t                    r_state;
   logic [C*H*W*DATA_LEN-1:0] r_buf;
   logic [C*K*K*DATA_LEN-1:0] r_q;
   logic [YW-1:0]             r_y;
   logic [XW-1:0]             r_x;
   logic                      r_valid;
   logic                      r_last;
   logic                      r_in_ready;

   logic [YW-1:0]             w_nx_y;
   logic [XW-1:0]             w_nx_x;
   logic                      w_nx_last;
   logic [C*H*W*DATA_LEN-1:0] w_sel_buf;
   logic [C*K*K*DATA_LEN-1:0] w_patch;

   // Position of the patch to load next: (0,0) on capture, raster successor while emitting.
   always_comb begin
      w_nx_y = '0;
      w_nx_x = '0;
      if (r_state == ST_EMIT) begin
         if (r_x == LAST_X) begin
            w_nx_x = '0;
            w_nx_y = r_y + YW'(1);
         end else begin
            w_nx_x = r_x + XW'(1);
            w_nx_y = r_y;
         end
      end else begin
         w_nx_x = '0;
         w_nx_y = '0;
      end
   end

   // The first patch is gathered straight from d so it is ready one cycle after capture.
   assign w_sel_buf = (r_state == ST_IDLE) ? d : r_buf;
   assign w_nx_last = (w_nx_y == LAST_Y) && (w_nx_x == LAST_X);

   im2col_patch_sel #(
      .DATA_LEN (DATA_LEN),
      .C        (C),
      .H        (H),
      .W        (W),
      .K        (K),
      .YW       (YW),
      .XW       (XW)
   ) u_patch_sel (
      .i_buf   (w_sel_buf),
      .i_y     (w_nx_y),
      .i_x     (w_nx_x),
      .o_patch (w_patch)
   );

   // Capture/emit FSM with registered stream outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_buf      <= '0;
         r_q        <= '0;
         r_y        <= '0;
         r_x        <= '0;
         r_valid    <= 1'b0;
         r_last     <= 1'b0;
         r_in_ready <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_buf      <= d;
                  r_q        <= w_patch;
                  r_y        <= '0;
                  r_x        <= '0;
                  r_last     <= w_nx_last;
                  r_valid    <= 1'b1;
                  r_in_ready <= 1'b0;
                  r_state    <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (r_valid && out_ready) begin
                  if (r_last) begin
                     r_valid    <= 1'b0;
                     r_last     <= 1'b0;
                     r_in_ready <= 1'b1;
                     r_state    <= ST_IDLE;
                  end else begin
                     r_q    <= w_patch;
                     r_y    <= w_nx_y;
                     r_x    <= w_nx_x;
                     r_last <= w_nx_last;
                  end
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_valid    <= 1'b0;
               r_last     <= 1'b0;
               r_in_ready <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_valid;
   assign q         = r_q;
   assign out_y     = r_y;
   assign out_x     = r_x;
   assign out_last  = r_last;

endmodule

// File: tb/tb_im2col_stream.sv
// Directed self-checking bench for im2col_stream: small map (C=2,H=4,W=4,K=3), default
// parameters, and a 1x3x3 map that is degenerate without IM2COL_PAD_EN and 3x3 with it.
module tb_im2col_stream;

   localparam int DL = 16;
`ifdef IM2COL_PAD_EN
   localparam int PADV = 1;
`else
   localparam int PADV = 0;
`endif

   function automatic int bw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int A_C = 2, A_H = 4, A_W = 4, A_K = 3;
   localparam int A_OH = A_H - A_K + 1 + 2*PADV, A_OW = A_W - A_K + 1 + 2*PADV;
   localparam int A_NP = A_OH * A_OW, A_YW = bw(A_OH), A_XW = bw(A_OW);
   localparam int A_DW = A_C*A_H*A_W*DL, A_QW = A_C*A_K*A_K*DL;

   localparam int B_C = 32, B_H = 5, B_W = 6, B_K = 3;
   localparam int B_OH = B_H - B_K + 1 + 2*PADV, B_OW = B_W - B_K + 1 + 2*PADV;
   localparam int B_NP = B_OH * B_OW, B_YW = bw(B_OH), B_XW = bw(B_OW);
   localparam int B_DW = B_C*B_H*B_W*DL, B_QW = B_C*B_K*B_K*DL;

   localparam int C_C = 1, C_H = 3, C_W = 3, C_K = 3;
   localparam int C_OH = C_H - C_K + 1 + 2*PADV, C_OW = C_W - C_K + 1 + 2*PADV;
   localparam int C_NP = C_OH * C_OW, C_YW = bw(C_OH), C_XW = bw(C_OW);
   localparam int C_DW = C_C*C_H*C_W*DL, C_QW = C_C*C_K*C_K*DL;

`ifdef IM2COL_PAD_EN
   int c_hand0 [9] = '{0, 0, 0, 0, 1, 2, 0, 4, 5};
   int c_hand_n    = 4;
`else
   int c_hand0 [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
   int c_hand_n    = 0;
`endif
   int c_hand1 [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};

   logic clk;
   logic a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
   logic [A_DW-1:0] a_d;
   logic [A_QW-1:0] a_q;
   logic [A_YW-1:0] a_out_y;
   logic [A_XW-1:0] a_out_x;
   logic b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
   logic [B_DW-1:0] b_d;
   logic [B_QW-1:0] b_q;
   logic [B_YW-1:0] b_out_y;
   logic [B_XW-1:0] b_out_x;
   logic c_rst, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last;
   logic [C_DW-1:0] c_d;
   logic [C_QW-1:0] c_q;
   logic [C_YW-1:0] c_out_y;
   logic [C_XW-1:0] c_out_x;

   int n_checks = 0;
   int n_pass   = 0;

   im2col_stream #(.DATA_LEN(DL), .C(A_C), .H(A_H), .W(A_W), .K(A_K)) u_dut_a (
      .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .d(a_d),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .q(a_q),
      .out_y(a_out_y), .out_x(a_out_x), .out_last(a_out_last));

   im2col_stream #(.DATA_LEN(DL), .C(B_C), .H(B_H), .W(B_W), .K(B_K)) u_dut_b (
      .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .d(b_d),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .q(b_q),
      .out_y(b_out_y), .out_x(b_out_x), .out_last(b_out_last));

   im2col_stream #(.DATA_LEN(DL), .C(C_C), .H(C_H), .W(C_W), .K(C_K)) u_dut_c (
      .clk(clk), .rst(c_rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .d(c_d),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .q(c_q),
      .out_y(c_out_y), .out_x(c_out_x), .out_last(c_out_last));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk_eq(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Seed 0 gives element value = flat index, seed -1 gives flat index + 1.
   function automatic int map_val(input int seed, input int idx);
      if (seed == 0) return idx;
      if (seed < 0) return idx + 1;
      return (idx * (2*seed + 1) + seed * 4369) & 65535;
   endfunction

   function automatic int exp_el(input int seed, input int cc, input int hh, input int ww,
                                 input int kk, input int y, input int x,
                                 input int c, input int r, input int s);
      int yy;
      int xx;
      yy = y + r - PADV;
      xx = x + s - PADV;
      if (yy < 0 || yy >= hh || xx < 0 || xx >= ww) return 0;
      return map_val(seed, c*hh*ww + yy*ww + xx);
   endfunction

   function automatic logic [A_DW-1:0] map_a(input int seed);
      logic [A_DW-1:0] m;
      m = '0;
      for (int i = 0; i < A_C*A_H*A_W; i++) m[i*DL +: DL] = DL'(map_val(seed, i));
      return m;
   endfunction

   function automatic logic [B_DW-1:0] map_b(input int seed);
      logic [B_DW-1:0] m;
      m = '0;
      for (int i = 0; i < B_C*B_H*B_W; i++) m[i*DL +: DL] = DL'(map_val(seed, i));
      return m;
   endfunction

   function automatic logic [C_DW-1:0] map_c(input int seed);
      logic [C_DW-1:0] m;
      m = '0;
      for (int i = 0; i < C_C*C_H*C_W; i++) m[i*DL +: DL] = DL'(map_val(seed, i));
      return m;
   endfunction

   task automatic chk_patch(input string tag, input logic [B_QW-1:0] qv, input int seed,
                            input int cc, input int hh, input int ww, input int kk,
                            input int y, input int x);
      for (int c = 0; c < cc; c++)
         for (int r = 0; r < kk; r++)
            for (int s = 0; s < kk; s++)
               chk_eq(tag, longint'(qv[(c*kk*kk + r*kk + s)*DL +: DL]),
                      longint'(exp_el(seed, cc, hh, ww, kk, y, x, c, r, s)));
   endtask

   // Capture map `seed` on instance A and consume its patches; rmode 1 = ready 1,0,0,...
   task automatic a_stream(input int seed, input int rmode, input int busy_seed,
                           input int stop_after, input bit hand);
      int n;
      int cyc;
      logic [A_QW-1:0] pq;
      logic [A_YW-1:0] py;
      logic [A_XW-1:0] px;
      logic pl;
      bit stalled;
      n = 0; cyc = 0; stalled = 1'b0; pq = '0; py = '0; px = '0; pl = 1'b0;
      a_d = map_a(seed);
      a_in_valid = 1'b1;
      a_out_ready = 1'b0;
      tick();
      if (busy_seed >= 0) a_d = map_a(busy_seed);
      else a_in_valid = 1'b0;
      while (n < A_NP && cyc < 200) begin
         if (stop_after >= 0 && n == stop_after) break;
         a_out_ready = (rmode == 0) || (cyc % 3 == 0);
         chk_eq("a_out_valid", longint'(a_out_valid), longint'(1));
         if (busy_seed >= 0) chk_eq("a_busy_in_ready", longint'(a_in_ready), longint'(0));
         if (stalled) begin
            chk_eq("a_stall_q", longint'(a_q == pq), longint'(1));
            chk_eq("a_stall_y", longint'(a_out_y), longint'(py));
            chk_eq("a_stall_x", longint'(a_out_x), longint'(px));
            chk_eq("a_stall_last", longint'(a_out_last), longint'(pl));
         end
         chk_eq("a_out_y", longint'(a_out_y), longint'(n / A_OW));
         chk_eq("a_out_x", longint'(a_out_x), longint'(n % A_OW));
         chk_eq("a_out_last", longint'(a_out_last), longint'(n == A_NP - 1));
         chk_patch("a_patch", B_QW'(a_q), seed, A_C, A_H, A_W, A_K, n / A_OW, n % A_OW);
         if (hand && n == 0) begin
`ifdef IM2COL_PAD_EN
            chk_eq("a_p00_000", longint'(a_q[0*DL +: DL]), longint'(0));
            chk_eq("a_p00_011", longint'(a_q[4*DL +: DL]), longint'(0));
            chk_eq("a_p00_022", longint'(a_q[8*DL +: DL]), longint'(5));
            chk_eq("a_p00_122", longint'(a_q[17*DL +: DL]), longint'(21));
`else
            chk_eq("a_p00_000", longint'(a_q[0*DL +: DL]), longint'(0));
            chk_eq("a_p00_001", longint'(a_q[1*DL +: DL]), longint'(1));
            chk_eq("a_p00_002", longint'(a_q[2*DL +: DL]), longint'(2));
            chk_eq("a_p00_122", longint'(a_q[17*DL +: DL]), longint'(26));
`endif
         end
         stalled = a_out_valid && !a_out_ready;
         pq = a_q; py = a_out_y; px = a_out_x; pl = a_out_last;
         if (a_out_valid && a_out_ready) n++;
         cyc++;
         tick();
      end
      a_out_ready = 1'b0;
      if (stop_after >= 0) begin
         chk_eq("a_hs_count", longint'(n), longint'(stop_after));
      end else begin
         chk_eq("a_hs_count", longint'(n), longint'(A_NP));
         chk_eq("a_cycles", longint'(cyc), longint'((rmode == 0) ? A_NP : 3*A_NP - 2));
      end
   endtask

   initial begin
      int n;
      int cyc;
      a_rst = 1'b1; a_in_valid = 1'b0; a_out_ready = 1'b0; a_d = '0;
      b_rst = 1'b1; b_in_valid = 1'b0; b_out_ready = 1'b0; b_d = '0;
      c_rst = 1'b1; c_in_valid = 1'b0; c_out_ready = 1'b0; c_d = '0;
      tick();
      tick();
      chk_eq("rst_in_ready", longint'(a_in_ready), longint'(1));
      chk_eq("rst_out_valid", longint'(a_out_valid), longint'(0));
      chk_eq("rst_out_last", longint'(a_out_last), longint'(0));
      chk_eq("rst_out_y", longint'(a_out_y), longint'(0));
      chk_eq("rst_out_x", longint'(a_out_x), longint'(0));
      chk_eq("rst_q_zero", longint'(a_q == '0), longint'(1));
      chk_eq("rst_b_in_ready", longint'(b_in_ready), longint'(1));
      a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

      a_stream(0, 0, -1, -1, 1'b1);
      chk_eq("a_bubble_valid", longint'(a_out_valid), longint'(0));
      chk_eq("a_bubble_in_ready", longint'(a_in_ready), longint'(1));

      a_stream(0, 1, -1, -1, 1'b0);

      // Busy map held on d throughout; it must be taken only in the bubble after out_last.
      a_stream(0, 0, 1, -1, 1'b0);
      chk_eq("a_busy_bubble_valid", longint'(a_out_valid), longint'(0));
      chk_eq("a_busy_bubble_in_ready", longint'(a_in_ready), longint'(1));
      a_stream(1, 0, -1, -1, 1'b0);

      a_stream(0, 0, -1, 2, 1'b0);
      a_rst = 1'b1;
      tick();
      chk_eq("a_midrst_valid", longint'(a_out_valid), longint'(0));
      chk_eq("a_midrst_in_ready", longint'(a_in_ready), longint'(1));
      chk_eq("a_midrst_last", longint'(a_out_last), longint'(0));
      a_rst = 1'b0;
      a_stream(2, 0, -1, -1, 1'b0);

      b_d = map_b(3);
      b_in_valid = 1'b1;
      tick();
      b_in_valid = 1'b0;
      b_out_ready = 1'b1;
      n = 0;
      cyc = 0;
      while (n < B_NP && cyc < 100) begin
         chk_eq("b_out_valid", longint'(b_out_valid), longint'(1));
         chk_eq("b_out_y", longint'(b_out_y), longint'(n / B_OW));
         chk_eq("b_out_x", longint'(b_out_x), longint'(n % B_OW));
         chk_eq("b_out_last", longint'(b_out_last), longint'(n == B_NP - 1));
         chk_patch("b_patch", b_q, 3, B_C, B_H, B_W, B_K, n / B_OW, n % B_OW);
         if (b_out_valid) n++;
         cyc++;
         tick();
      end
      b_out_ready = 1'b0;
      chk_eq("b_hs_count", longint'(n), longint'(B_NP));
      chk_eq("b_done_valid", longint'(b_out_valid), longint'(0));

      c_d = map_c(-1);
      c_in_valid = 1'b1;
      tick();
      c_in_valid = 1'b0;
      c_out_ready = 1'b1;
      n = 0;
      cyc = 0;
      while (n < C_NP && cyc < 100) begin
         chk_eq("c_out_valid", longint'(c_out_valid), longint'(1));
         chk_eq("c_out_y", longint'(c_out_y), longint'(n / C_OW));
         chk_eq("c_out_x", longint'(c_out_x), longint'(n % C_OW));
         chk_eq("c_out_last", longint'(c_out_last), longint'(n == C_NP - 1));
         chk_patch("c_patch", B_QW'(c_q), -1, C_C, C_H, C_W, C_K, n / C_OW, n % C_OW);
         if (n == 0) begin
            for (int i = 0; i < 9; i++)
               chk_eq("c_hand_first", longint'(c_q[i*DL +: DL]), longint'(c_hand0[i]));
         end
         if (n == c_hand_n) begin
            for (int i = 0; i < 9; i++)
               chk_eq("c_hand_centre", longint'(c_q[i*DL +: DL]), longint'(c_hand1[i]));
         end
         if (c_out_valid) n++;
         cyc++;
         tick();
      end
      c_out_ready = 1'b0;
      chk_eq("c_hs_count", longint'(n), longint'(C_NP));
      chk_eq("c_done_valid", longint'(c_out_valid), longint'(0));
      chk_eq("c_done_in_ready", longint'(c_in_ready), longint'(1));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/im2col_stream.md
Name: im2col_stream

Overview:
- Parametrised successor of the one-shot im2col stage in the CNN datapath.
- Captures a full C×H×W feature map in one cycle.
- Streams im2col patch vectors of C·K·K elements, one per handshake, in raster order (row y, then column x), to the downstream matrix-multiply stage.
- Replaces the fixed single-cycle all-patches output with a valid/ready stream, cutting output width from OH·OW patches to one patch.

Parameters:
- DATA_LEN, 16, bits per element.
- C, 32, input channels.
- H, 5, input height.
- W, 6, input width.
- K, 3, square kernel size; odd, K ≤ H, K ≤ W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  feature map on d is valid.
- in_ready  out  1  block can accept a map; high only in IDLE.
- d  in  C*H*W*DATA_LEN  map; element (c,y,x) at index c*H*W + y*W + x.
- out_valid  out  1  q holds a valid patch.
- out_ready  in  1  downstream accepts q.
- q  out  C*K*K*DATA_LEN  patch; element (c,r,s) at index c*K*K + r*K + s.
- out_y  out  clog2(OH)  output row of current patch.
- out_x  out  clog2(OW)  output column of current patch.
- out_last  out  1  current patch is the final patch (OH-1, OW-1).

Behaviour:
- Derived values: OH = H-K+1 and OW = W-K+1 without padding.
- Clock and reset: single clock clk. rst is synchronous and active-high; it is sampled only on the clk rising edge.
- Reset values: state=IDLE; buffer, q, out_y, out_x = 0; out_valid = 0; out_last = 0; in_ready = 1.
- FSM, state IDLE:
  - in_ready = 1.
  - On in_valid, d is captured into the internal buffer.
  - In the same edge, q <= patch(0,0), out_y/out_x <= 0 and out_valid <= 1.
  - State moves to EMIT, so latency from capture to the first valid patch is 1 cycle.
- FSM, state EMIT:
  - in_ready = 0; in_valid is ignored.
  - Handshake occurs when out_valid && out_ready.
  - On handshake with out_last = 0: advance x; when x wraps from OW-1 to 0, y increments. q, out_y and out_x are updated at the same edge, so no bubble is inserted between patches.
  - On handshake with out_last = 1: out_valid <= 0 and state returns to IDLE.
  - One bubble cycle separates the final patch from the next capture.
- Patch content: patch(y,x) element (c,r,s) = buffer element (c, y+r, x+s).
- Stall: while out_valid && !out_ready, q, out_y, out_x and out_last are held stable.
- out_last is registered and must equal (out_y==OH-1 && out_x==OW-1) whenever out_valid = 1.
- Degenerate case: when OH = OW = 1, the first patch has out_last = 1.
- Reset mid-stream: all state returns to reset values at the next edge; the partially sent map is dropped.
- The buffer is not cleared between maps; it is overwritten only on capture.
- Arithmetic: all indices are computed from unsigned parameters; there is no data arithmetic.

Optional Feature:
- Macro: IM2COL_PAD_EN.
- Defined: "same" zero padding with P = (K-1)/2.
  - OH = H and OW = W.
  - patch(y,x) element (c,r,s) = buffer(c, y+r-P, x+s-P) when that position is in range, otherwise 0.
  - Port widths follow the new OH and OW.
- Undefined: no padding; OH = H-K+1, OW = W-K+1.

Decomposition:
- Shared include / package (alongside num_data.v):
  - DATA_LEN default.
  - clog2 function.
  - Macros or functions for OH/OW derivation.
  - Index helper for flattening (c,y,x) to a flat element index.
- One natural sub-module: im2col_patch_sel.
  - Combinational gather that takes the buffer, y and x and produces the C·K·K patch.
  - Padding mux lives here under IM2COL_PAD_EN.
- im2col_stream owns the buffer, FSM, counters and output registers.

Test Plan:
- Reset and first patch: C=2,H=4,W=4,K=3, d element value = its flat index; rst held 2 cycles, then in_valid=1 with out_ready=1.
  - Required: 4 patches on consecutive cycles.
  - patch(0,0) elements (0,0,0)…(0,0,2) = 0,1,2; element (1,2,2) = 26.
  - out_last high on the 4th patch only.
- Backpressure: same map, out_ready toggling 1,0,0,1,…
  - Required: q, out_y and out_x stable while stalled.
  - Exactly 4 handshakes; patch order (0,0),(0,1),(1,0),(1,1).
- Busy ignore: in_valid pulsed during EMIT with a different d.
  - Required: in_ready = 0 and patches unchanged.
  - Next capture is accepted only after the cycle after out_last handshakes.
- Reset mid-stream: rst after 2 handshakes.
  - Required: next edge gives out_valid = 0 and in_ready = 1.
  - A new map restarts at (0,0).
- Default parameters C=32,H=5,W=6,K=3: 12 patches of 288 elements each.
  - Required: patch(y,x) element (c,r,s) = d element (c, y+r, x+s), checked for all 12 patches.
- IM2COL_PAD_EN, C=1,H=3,W=3,K=3, d = 1..9.
  - Required: 9 patches.
  - patch(0,0) = 0,0,0,0,1,2,0,4,5.
  - patch(1,1) = 1..9.
